// File: rtl/mdu_hilo.sv
// Iterative MIPS multiply/divide unit with HI/LO registers (shift-add multiply, restoring divide).
// Optional divide-by-zero flag output enabled by defining MDU_DIV0_FLAG_EN.
module mdu_hilo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
`ifdef MDU_DIV0_FLAG_EN
    output logic             div0,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned RW = WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               is_div;
    logic               sign_a;
    logic               neg_res;
    logic               bzero;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;

    logic               sgn_op;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH+1:0]   div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy = (state != IDLE);

    always_comb begin
        sgn_op    = (op == OP_MULT) || (op == OP_DIV);
        sa        = sgn_op & a[WIDTH-1];
        sb        = sgn_op & b[WIDTH-1];
        abs_a     = sa ? (-a) : a;
        abs_b     = sb ? (-b) : b;
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);
        div_shift = {rem, quo[WIDTH-1]};
        div_ge    = div_shift >= {2'b00, mag_b};
        div_sub   = div_shift - {2'b00, mag_b};
        prod_fix  = neg_res ? (-prod) : prod;
        // With b==0 the quotient is already all ones; the remainder sign fix restores a exactly.
        quo_fix   = (neg_res && !bzero) ? (-quo) : quo;
        rem_fix   = sign_a ? (-rem[WIDTH-1:0]) : rem[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            is_div  <= 1'b0;
            sign_a  <= 1'b0;
            neg_res <= 1'b0;
            bzero   <= 1'b0;
            prod    <= '0;
            rem     <= '0;
            quo     <= '0;
            hi      <= '0;
            lo      <= '0;
`ifdef MDU_DIV0_FLAG_EN
            div0    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                mag_a   <= abs_a;
                                mag_b   <= abs_b;
                                is_div  <= (op == OP_DIV) || (op == OP_DIVU);
                                sign_a  <= sa;
                                neg_res <= sa ^ sb;
                                bzero   <= (b == '0);
                                prod    <= {{WIDTH{1'b0}}, abs_b};
                                rem     <= '0;
                                quo     <= abs_a;
                                cnt     <= '0;
                                state   <= RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            rem <= RW'(div_ge ? div_sub : div_shift);
                            quo <= {quo[WIDTH-2:0], div_ge};
                        end else begin
                            prod <= {mul_sum, prod[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= FIX;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                        lo <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
`ifdef MDU_DIV0_FLAG_EN
                        div0 <= is_div && bzero;
`endif
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed plan vectors plus randomized ops against an arithmetic model.
// Exercises the div0 flag too when built with MDU_DIV0_FLAG_EN.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_DIV0_FLAG_EN
    logic        div0;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_div0;

    always #5 clk = ~clk;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
`ifdef MDU_DIV0_FLAG_EN
        .div0  (div0),
`endif
        .hi    (hi),
        .lo    (lo)
    );

    // Reference model: plain 64-bit arithmetic on the architectural result.
    task automatic ref_apply(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] pu;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd1: begin p = sx * sy; exp_hi = p[63:32]; exp_lo = p[31:0]; exp_div0 = 1'b0; end
            3'd2: begin pu = {32'b0, x} * {32'b0, y}; exp_hi = pu[63:32]; exp_lo = pu[31:0]; exp_div0 = 1'b0; end
            3'd3: begin
                if (y == 0) begin exp_hi = x; exp_lo = '1; exp_div0 = 1'b1; end
                else begin q = sx / sy; r = sx % sy; exp_hi = r[31:0]; exp_lo = q[31:0]; exp_div0 = 1'b0; end
            end
            3'd4: begin
                if (y == 0) begin exp_hi = x; exp_lo = '1; exp_div0 = 1'b1; end
                else begin exp_hi = x % y; exp_lo = x / y; exp_div0 = 1'b0; end
            end
            3'd5: exp_hi = x;
            3'd6: exp_lo = x;
            default: ;
        endcase
    endtask

    task automatic check_regs(input string name);
        checks++;
        if (hi !== exp_hi) begin errors++; $display("FAIL %s hi got %h exp %h", name, hi, exp_hi); end
        checks++;
        if (lo !== exp_lo) begin errors++; $display("FAIL %s lo got %h exp %h", name, lo, exp_lo); end
`ifdef MDU_DIV0_FLAG_EN
        checks++;
        if (div0 !== exp_div0) begin errors++; $display("FAIL %s div0 got %b exp %b", name, div0, exp_div0); end
`endif
    endtask

    // Issue one op, optionally poke ignored starts while busy, then check latency and results.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit poke, input string name);
        int n;
        int exp_n;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            if (poke && (n == 5 || n == 20 || n == 33)) begin
                start = 1'b1;
                op = (n == 20) ? 3'd4 : 3'd5;
                a = $urandom;
            end else begin
                start = 1'b0;
                op = 3'd0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        op = 3'd0;
        exp_n = (o >= 3'd1 && o <= 3'd4) ? 33 : 0;
        checks++;
        if (n != exp_n) begin errors++; $display("FAIL %s busy_cycles got %0d exp %0d", name, n, exp_n); end
        ref_apply(o, x, y);
        check_regs(name);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        exp_hi = '0; exp_lo = '0; exp_div0 = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
        check_regs("reset");
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        run_op(3'd1, 32'hFFFFFFFD, 32'd7, 1'b0, "mult_neg");
        run_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, "multu_max");
        run_op(3'd4, 32'd100, 32'd7, 1'b0, "divu_basic");
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, "div_neg");
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
        run_op(3'd4, 32'h00001234, 32'd0, 1'b0, "divu_zero");
        run_op(3'd3, 32'hFFFFFF00, 32'd0, 1'b0, "div_zero_neg");
        run_op(3'd5, 32'h0000BEEF, 32'd0, 1'b0, "mthi_keeps_flag");
        run_op(3'd1, 32'd9, 32'hFFFFFFFF, 1'b0, "mult_clears_flag");
    endtask

    task automatic test_flush;
        run_op(3'd5, 32'h0000AAAA, 32'd0, 1'b0, "setup_mthi");
        run_op(3'd6, 32'h00005555, 32'd0, 1'b0, "setup_mtlo");
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_run busy got %b exp 0", busy); end
        check_regs("flush_run");
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'h0000DEAD; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'd0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle busy got %b exp 0", busy); end
        check_regs("flush_idle");
    endtask

    task automatic test_back_to_back;
        run_op(3'd1, 32'h12345678, 32'h9ABCDEF0, 1'b1, "poke_mult");
        run_op(3'd3, 32'h7FFFFFFF, 32'hFFFFFFFD, 1'b1, "poke_div");
        run_op(3'd0, 32'h11111111, 32'h2, 1'b0, "op_none");
        run_op(3'd7, 32'h22222222, 32'h3, 1'b0, "op_reserved");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_hi = '0; exp_lo = '0; exp_div0 = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy got %b exp 0", busy); end
        check_regs("reset_mid");
        run_op(3'd2, 32'd3, 32'd5, 1'b0, "multu_after_reset");
    endtask

    task automatic test_random;
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            case ($urandom_range(0, 5))
                0: y = '0;
                1: y = 32'hFFFFFFFF;
                2: y = 32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) x = 32'h80000000;
            run_op(o, x, y, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
